// File: rtl/req_ack_tx_bridge.sv
// Clocked valid/ready to four-phase bundled-data bridge feeding a req/ack micropipeline head.
// Latency: word accepted at E0 appears on data_out at E1, req_out rises at E(2+SETUP_CYC).
// Backpressure: in_ready drops when the FIFO is full; a stalled ack holds the FSM in REQ_HI/REQ_LO.
module req_ack_tx_bridge #(
  parameter int WIDTH     = 3,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       req_out,
  input  logic                       ack_in,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_REQ_HI,
    S_REQ_LO
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ack_s1;
  logic             r_ack_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_setup;
  logic [3:0]       w_setup_nxt;
  logic             r_req;
  logic             w_req_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_perr;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push    = in_valid && !w_full;
  assign in_ready  = !w_full;
  assign count     = r_count;
  assign req_out   = r_req;
  assign data_out  = r_data;
  assign busy      = (r_state != S_IDLE);
  assign proto_err = r_perr;

  // FIFO storage: written on push only; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous acknowledge; only r_ack_s is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s  <= 1'b0;
    end else begin
      r_ack_s1 <= ack_in;
      r_ack_s  <= r_ack_s1;
    end
  end

  // Sticky protocol error: an acknowledge while no request can be outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (r_ack_s && (r_state == S_IDLE || r_state == S_SETUP)) begin
      r_perr <= 1'b1;
    end
  end

  // Handshake FSM state, setup counter, request and bundled data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_setup <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_setup <= w_setup_nxt;
      r_req   <= w_req_nxt;
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
      end
    end
  end

  // Next-state logic: data is popped only in IDLE or on REQ_LO exit, so it is stable while req_out is high.
  always_comb begin
    w_state_nxt = r_state;
    w_setup_nxt = r_setup;
    w_req_nxt   = r_req;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_setup_nxt = SETUP_LD;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_setup == 4'd0) begin
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ_HI;
        end else begin
          w_setup_nxt = r_setup - 4'd1;
        end
      end
      S_REQ_HI: begin
        if (r_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        // Leaving only once ack_s is low guarantees req_out never rises against a high ack.
        if (!r_ack_s) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_setup_nxt = SETUP_LD;
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_req_ack_tx_bridge.sv
// Bench for req_ack_tx_bridge: directed timing sequences plus a scoreboarded responder.
// Edge numbering below: E0 is the edge that accepts the push; an ack driven after edge Ek-1
// is first sampled at Ek, reaches ack_s at Ek+1 and is acted on by the FSM at Ek+2.
module tb_req_ack_tx_bridge;
  localparam int W  = 3;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid, in_ready, req_out, ack_in, busy, proto_err;
  logic [W-1:0]  in_data, data_out;
  logic [CW-1:0] count;
  logic          in_valid0, in_ready0, req_out0, ack_in0, busy0, proto_err0;
  logic [W-1:0]  in_data0, data_out0;
  logic [CW-1:0] count0;

  logic resp_en, resp_hold, resp_ack, man_ack;
  int   total, bad, n_recv;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]  d;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          rdy;
  } vec_t;

  assign ack_in = resp_en ? resp_ack : man_ack;

  req_ack_tx_bridge #(.WIDTH(W), .DEPTH(D), .SETUP_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_out(req_out), .ack_in(ack_in), .data_out(data_out), .count(count), .busy(busy),
    .proto_err(proto_err)
  );

  req_ack_tx_bridge #(.WIDTH(W), .DEPTH(D), .SETUP_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .req_out(req_out0), .ack_in(ack_in0), .data_out(data_out0), .count(count0), .busy(busy0),
    .proto_err(proto_err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, output logic acc);
    in_valid = 1'b1;
    in_data  = d;
    acc      = in_ready;
    step();
    in_valid = 1'b0;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic push_wait(input logic [W-1:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      push(d, acc);
      n++;
    end
    check("push_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && count == 0) && n < budget) begin
      step();
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && !busy && count == 0)}, 32'd1);
  endtask

  // Single word with manual ack 3 cycles after req; checks cycle-exact handshake timing.
  task automatic t_single(input logic [W-1:0] d);
    logic         acc;
    logic [W-1:0] e;
    push(d, acc);                                          // E0
    check("s_acc", {31'd0, acc}, 32'd1);
    check("s_cnt_e0", count, 32'd1);
    step();                                                // E1
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("s_data_e1", data_out, e);
    check("s_req_e1", req_out, 32'd0);
    check("s_cnt_e1", count, 32'd0);
    check("s_busy_e1", busy, 32'd1);
    step();                                                // E2
    check("s_req_e2", req_out, 32'd0);
    step();                                                // E3
    check("s_req_e3", req_out, 32'd1);
    repeat (3) step();                                     // E4..E6
    man_ack = 1'b1;
    step();                                                // E7: ack first sampled
    check("s_req_e7", req_out, 32'd1);
    step();                                                // E8: ack_s high
    check("s_req_e8", req_out, 32'd1);
    step();                                                // E9: req falls
    check("s_req_e9", req_out, 32'd0);
    check("s_data_e9", data_out, e);
    man_ack = 1'b0;
    step();                                                // E10
    step();                                                // E11
    check("s_busy_e11", busy, 32'd1);
    step();                                                // E12: back to IDLE
    check("s_busy_e12", busy, 32'd0);
    check("s_cnt_end", count, 32'd0);
    check("s_perr", proto_err, 32'd0);
  endtask

  // Responder/consumer: scoreboard-checks each word when req rises, acks after 1..3 cycles.
  initial begin : responder
    int           st;
    int           cnt;
    logic [W-1:0] cap;
    st       = 0;
    cnt      = 0;
    cap      = '0;
    resp_ack = 1'b0;
    forever begin
      step();
      if (resp_en) begin
        case (st)
          0: if (req_out && !resp_hold) begin
               if (exp_q.size() == 0) begin
                 total++;
                 bad++;
                 $display("FAIL sb_underflow: got word %0h, expected none", data_out);
               end else begin
                 check("sb_data", data_out, exp_q.pop_front());
               end
               cap = data_out;
               n_recv++;
               cnt = $urandom_range(1, 3);
               st  = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 resp_ack = 1'b1;
                 st       = 2;
               end
             end
          default: if (!req_out) begin
               check("sb_hold", data_out, cap);
               resp_ack = 1'b0;
               st       = 0;
             end
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    logic acc;
    int   n0;
    int   n;
    total = 0; bad = 0; n_recv = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid0 = 1'b0; in_data0 = '0; ack_in0 = 1'b0;
    man_ack = 1'b0; resp_en = 1'b0; resp_hold = 1'b0;

    // Stalled responder: word 1 moves to data_out at E1, FIFO fills, 6th push refused.
    tbl[0] = '{3'd1, 1'b1, 3'd1, 1'b1};
    tbl[1] = '{3'd2, 1'b1, 3'd1, 1'b1};
    tbl[2] = '{3'd3, 1'b1, 3'd2, 1'b1};
    tbl[3] = '{3'd4, 1'b1, 3'd3, 1'b1};
    tbl[4] = '{3'd5, 1'b1, 3'd4, 1'b0};
    tbl[5] = '{3'd6, 1'b0, 3'd4, 1'b0};

    #3;
    check("rst_req", req_out, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_cnt", count, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_perr", proto_err, 32'd0);
    check("rst_rdy", in_ready, 32'd1);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();

    t_single(3'b101);

    // SETUP_CYC=0 instance: req at E2 with data already stable.
    in_valid0 = 1'b1; in_data0 = 3'b110;
    step();                                                // E0
    in_valid0 = 1'b0;
    step();                                                // E1
    check("z_data_e1", data_out0, 32'h6);
    check("z_req_e1", req_out0, 32'd0);
    step();                                                // E2
    check("z_req_e2", req_out0, 32'd1);
    check("z_data_e2", data_out0, 32'h6);
    ack_in0 = 1'b1;
    n = 0;
    while (req_out0 && n < 20) begin step(); n++; end
    check("z_req_fall", req_out0, 32'd0);
    ack_in0 = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin step(); n++; end
    check("z_idle", busy0, 32'd0);

    // Full FIFO behind a stalled pipeline, then drain in order.
    resp_en = 1'b1; resp_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].d, acc);
      check($sformatf("full_acc%0d", i), {31'd0, acc}, {31'd0, tbl[i].acc});
      check($sformatf("full_cnt%0d", i), count, tbl[i].cnt);
      check($sformatf("full_rdy%0d", i), in_ready, tbl[i].rdy);
    end
    check("full_held", data_out, 32'd1);
    check("full_req", req_out, 32'd1);
    n0 = n_recv;
    resp_hold = 1'b0;
    wait_idle(400, "drain_idle");
    check("drain_n", n_recv - n0, 32'd5);

    // Back-to-back stream 0..7: pointers wrap twice.
    n0 = n_recv;
    for (int i = 0; i < 8; i++) push_wait(3'(i));
    wait_idle(600, "stream_idle");
    check("stream_n", n_recv - n0, 32'd8);
    resp_en = 1'b0;
    repeat (3) step();

    // Reset asserted mid-transfer in REQ_HI with two words queued.
    push(3'd2, acc);                                       // E0
    push(3'd3, acc);                                       // E1
    push(3'd4, acc);                                       // E2
    step();                                                // E3
    check("mr_pre_req", req_out, 32'd1);
    check("mr_pre_cnt", count, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mr_req", req_out, 32'd0);
    check("mr_data", data_out, 32'd0);
    check("mr_cnt", count, 32'd0);
    check("mr_busy", busy, 32'd0);
    check("mr_rdy", in_ready, 32'd1);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    t_single(3'b011);

    // Stray ack in IDLE: proto_err two edges after first sample, sticky, no request.
    man_ack = 1'b1;
    step();                                                // Ek
    check("pe_k0", proto_err, 32'd0);
    step();                                                // Ek+1
    check("pe_k1", proto_err, 32'd0);
    step();                                                // Ek+2
    man_ack = 1'b0;
    check("pe_k2", proto_err, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("pe_hold%0d", i), proto_err, 32'd1);
      check($sformatf("pe_req%0d", i), req_out, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
